// File: rtl/haar_mc_pkg.sv
// Shared types and helpers for the multi-channel Haar analysis filter bank.
package haar_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        LAST = 2'd2
    } state_t;

    localparam int WORD_W = 4;

    // Positive diff shifts left; negative diff shifts arithmetically right, optionally rounding half up.
    function automatic logic signed [63:0] scale_shift(
        input logic signed [63:0] v,
        input int                 diff,
        input logic               rnd
    );
        logic signed [63:0] r;
        if (diff >= 0) begin
            r = v <<< diff;
        end else if (rnd) begin
            r = (v + (64'sd1 <<< (-diff - 1))) >>> (-diff);
        end else begin
            r = v >>> (-diff);
        end
        return r;
    endfunction

endpackage

// File: rtl/haar_mc_butterfly.sv
// Combinational Haar butterfly: halved sum (b+a) and halved difference (b-a).
// Build option HAAR_MC_ROUND_EN rounds half up instead of truncating.
module haar_mc_butterfly #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] dif
);

    logic [W:0] sum_full_s;
    logic [W:0] dif_full_s;

    // One extra bit of headroom, then drop the LSB.
    always_comb begin
        sum_full_s = {a[W-1], a} + {b[W-1], b};
        dif_full_s = {b[W-1], b} - {a[W-1], a};
`ifdef HAAR_MC_ROUND_EN
        sum_full_s = sum_full_s + (W+1)'(1);
        dif_full_s = dif_full_s + (W+1)'(1);
`endif
        sum = $signed(sum_full_s[W:1]);
        dif = $signed(dif_full_s[W:1]);
    end

endmodule

// File: rtl/haar_filter_bank_mc.sv
// Time-multiplexed multi-channel Haar analysis cascade sharing one butterfly.
// Build option HAAR_MC_ROUND_EN enables round-half-up in the butterfly and output scaling.
module haar_filter_bank_mc
    import haar_mc_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int STAGES         = 4,
    parameter int IN_WIDTH       = 16,
    parameter int INTERNAL_WIDTH = 20,
    parameter int OUT_WIDTH      = 16,
    parameter int CHAN_W         = 2
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [CHAN_W-1:0]           inChan,
    input  logic signed [IN_WIDTH-1:0]  dataIn,
    output logic                        outValid,
    output logic [CHAN_W-1:0]           outChan,
    output logic [WORD_W-1:0]           outWord,
    output logic signed [OUT_WIDTH-1:0] dataOut
);

    localparam int S_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int NCH = 2 ** CHAN_W;
    localparam int NST = 2 ** S_W;
`ifdef HAAR_MC_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    state_t                           state_r;
    logic signed [INTERNAL_WIDTH-1:0] h_r [NCH][NST];
    logic [NST-1:0]                   f_r [NCH];
    logic signed [INTERNAL_WIDTH-1:0] a_r;
    logic signed [INTERNAL_WIDTH-1:0] b_r;
    logic signed [INTERNAL_WIDTH-1:0] low_r;
    logic [S_W-1:0]                   s_r;
    logic [CHAN_W-1:0]                c_r;

    logic signed [INTERNAL_WIDTH-1:0] sample_s;
    logic signed [INTERNAL_WIDTH-1:0] sum_s;
    logic signed [INTERNAL_WIDTH-1:0] dif_s;
    logic [S_W-1:0]                   nxt_s;
    logic                             legal_s;

    // Input scaling, next-stage index and channel legality.
    always_comb begin
        sample_s = INTERNAL_WIDTH'(scale_shift(64'(dataIn), INTERNAL_WIDTH - IN_WIDTH, 1'b0));
        nxt_s    = s_r + S_W'(1);
        legal_s  = 32'(inChan) < CHANNELS;
    end

    haar_mc_butterfly #(.W(INTERNAL_WIDTH)) u_bfly (
        .a   (a_r),
        .b   (b_r),
        .sum (sum_s),
        .dif (dif_s)
    );

    // Control FSM, per-channel held operands and registered coefficient output.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r  <= IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            outChan  <= '0;
            outWord  <= '0;
            dataOut  <= '0;
            a_r      <= '0;
            b_r      <= '0;
            low_r    <= '0;
            s_r      <= '0;
            c_r      <= '0;
            for (int i = 0; i < NCH; i++) begin
                f_r[i] <= '0;
            end
        end else begin
            outValid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (inValid && inReady && legal_s) begin
                        if (!f_r[inChan][0]) begin
                            h_r[inChan][0] <= sample_s;
                            f_r[inChan][0] <= 1'b1;
                        end else begin
                            a_r            <= h_r[inChan][0];
                            b_r            <= sample_s;
                            s_r            <= '0;
                            c_r            <= inChan;
                            f_r[inChan][0] <= 1'b0;
                            state_r        <= CALC;
                            inReady        <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    outValid <= 1'b1;
                    outChan  <= c_r;
                    outWord  <= WORD_W'(STAGES) - WORD_W'(s_r);
                    dataOut  <= OUT_WIDTH'(scale_shift(64'(dif_s), OUT_WIDTH - INTERNAL_WIDTH, RND));
                    if (s_r == S_W'(STAGES - 1)) begin
                        low_r   <= sum_s;
                        state_r <= LAST;
                    end else if (!f_r[c_r][nxt_s]) begin
                        h_r[c_r][nxt_s] <= sum_s;
                        f_r[c_r][nxt_s] <= 1'b1;
                        state_r         <= IDLE;
                        inReady         <= 1'b1;
                    end else begin
                        // Partner is waiting: chain straight into the next stage.
                        a_r             <= h_r[c_r][nxt_s];
                        b_r             <= sum_s;
                        f_r[c_r][nxt_s] <= 1'b0;
                        s_r             <= nxt_s;
                    end
                end
                LAST: begin
                    outValid <= 1'b1;
                    outChan  <= c_r;
                    outWord  <= '0;
                    dataOut  <= OUT_WIDTH'(scale_shift(64'(low_r), OUT_WIDTH - INTERNAL_WIDTH, RND));
                    state_r  <= IDLE;
                    inReady  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    inReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_haar_filter_bank_mc.sv
// Directed, table-driven bench for haar_filter_bank_mc (main, rounding and illegal-channel builds).
module tb_haar_filter_bank_mc;

    localparam int STG = 3;
`ifdef HAAR_MC_ROUND_EN
    localparam int RND_HP = 1;
`else
    localparam int RND_HP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       in_valid;
    logic [2:0][1:0]  in_chan;
    logic [2:0][15:0] data_in;
    wire  [2:0]       in_ready;
    wire  [2:0]       out_valid;
    wire  [2:0][1:0]  out_chan;
    wire  [2:0][3:0]  out_word;
    wire  [2:0][15:0] data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int inst;   // 0 main, 1 rounding, 2 illegal channel
        int act;    // 0 sample, 1 reset pulse
        int ch;
        int d;
        int n;      // expected number of coefficients
        int busy;   // expected cycles with inReady low
        int first;  // first high-pass value
        int rest;   // other high-pass values
        int lp;     // final low-pass value
    } vec_t;

    vec_t tbl[$];

    haar_filter_bank_mc #(.CHANNELS(2), .STAGES(STG), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                          .OUT_WIDTH(16), .CHAN_W(2)) u0 (
        .clk(clk), .rstN(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
        .inChan(in_chan[0]), .dataIn(data_in[0]), .outValid(out_valid[0]),
        .outChan(out_chan[0]), .outWord(out_word[0]), .dataOut(data_out[0]));

    haar_filter_bank_mc #(.CHANNELS(4), .STAGES(STG), .IN_WIDTH(16), .INTERNAL_WIDTH(16),
                          .OUT_WIDTH(16), .CHAN_W(2)) u1 (
        .clk(clk), .rstN(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
        .inChan(in_chan[1]), .dataIn(data_in[1]), .outValid(out_valid[1]),
        .outChan(out_chan[1]), .outWord(out_word[1]), .dataOut(data_out[1]));

    haar_filter_bank_mc #(.CHANNELS(3), .STAGES(STG), .IN_WIDTH(16), .INTERNAL_WIDTH(18),
                          .OUT_WIDTH(16), .CHAN_W(2)) u2 (
        .clk(clk), .rstN(rst_n), .inValid(in_valid[2]), .inReady(in_ready[2]),
        .inChan(in_chan[2]), .dataIn(data_in[2]), .outValid(out_valid[2]),
        .outChan(out_chan[2]), .outWord(out_word[2]), .dataOut(data_out[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        int w;
        int nseen;
        int busy;
        int exp_w;
        int exp_d;
        if (v.act == 1) begin
            pulse_reset();
            return;
        end
        w = 0;
        while (!in_ready[v.inst] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d ready_before", idx), int'(in_ready[v.inst]), 1);
        in_valid[v.inst] = 1'b1;
        in_chan[v.inst]  = 2'(v.ch);
        data_in[v.inst]  = 16'(v.d);
        @(negedge clk);
        in_valid[v.inst] = 1'b0;
        nseen = 0;
        busy  = 0;
        for (int kk = 1; kk <= 20; kk++) begin
            if (out_valid[v.inst]) begin
                exp_w = (nseen == STG) ? 0 : STG - nseen;
                exp_d = (nseen == 0) ? v.first : ((nseen == STG) ? v.lp : v.rest);
                chk($sformatf("v%0d out%0d chan*1000+word*100+cycle", idx, nseen),
                    int'(out_chan[v.inst]) * 1000 + int'(out_word[v.inst]) * 100 + kk,
                    v.ch * 1000 + exp_w * 100 + nseen + 2);
                chk($sformatf("v%0d out%0d data", idx, nseen),
                    int'($signed(data_out[v.inst])), exp_d);
                nseen++;
            end
            if (in_ready[v.inst]) break;
            busy++;
            @(negedge clk);
        end
        chk($sformatf("v%0d count", idx), nseen, v.n);
        chk($sformatf("v%0d busy", idx), busy, v.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = '0;
        in_chan  = '0;
        data_in  = '0;

        // Pair test, then constant 1000 on ch1
        tbl.push_back('{0, 0, 0, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 300, 1, 1, 100, 0, 0});
        for (int i = 1; i <= 8; i++) begin
            case (i)
                2, 6:    tbl.push_back('{0, 0, 1, 1000, 1, 1, 0, 0, 0});
                4:       tbl.push_back('{0, 0, 1, 1000, 2, 2, 0, 0, 0});
                8:       tbl.push_back('{0, 0, 1, 1000, 4, 4, 0, 0, 1000});
                default: tbl.push_back('{0, 0, 1, 1000, 0, 0, 0, 0, 0});
            endcase
        end
        // Further ch0 pairs cascade into the held stage-1 partial (internal 800)
        tbl.push_back('{0, 0, 0, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 300, 2, 2, 100, 0, 0});
        tbl.push_back('{0, 0, 0, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 300, 1, 1, 100, 0, 0});
        tbl.push_back('{0, 0, 0, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 300, 4, 4, 100, 0, 200});
        // Uneven ch1 data: stage-1 high-pass of (240, 0) internal is -30 out
        tbl.push_back('{0, 0, 1, 40, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 80, 1, 1, 20, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 2, 2, 0, -30, 0});
        // Interleave +500 on ch0 and -500 on ch1 from a clean state
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 1; i <= 4; i++) begin
            case (i)
                2:       begin
                    tbl.push_back('{0, 0, 0, 500, 1, 1, 0, 0, 0});
                    tbl.push_back('{0, 0, 1, -500, 1, 1, 0, 0, 0});
                end
                4:       begin
                    tbl.push_back('{0, 0, 0, 500, 2, 2, 0, 0, 0});
                    tbl.push_back('{0, 0, 1, -500, 2, 2, 0, 0, 0});
                end
                default: begin
                    tbl.push_back('{0, 0, 0, 500, 0, 0, 0, 0, 0});
                    tbl.push_back('{0, 0, 1, -500, 0, 0, 0, 0, 0});
                end
            endcase
        end
        // Rounding build: -1 then 0
        tbl.push_back('{1, 0, 0, -1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, RND_HP, 0, 0});
        // Illegal channel 3 is dropped, then a normal ch0 pair
        tbl.push_back('{2, 0, 3, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{2, 0, 3, 300, 0, 0, 0, 0, 0});
        tbl.push_back('{2, 0, 0, 100, 0, 0, 0, 0, 0});
        tbl.push_back('{2, 0, 0, 300, 1, 1, 100, 0, 0});

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset ready u%0d", i), int'(in_ready[i]), 1);
            chk($sformatf("reset outputs u%0d", i),
                int'(out_valid[i]) + int'(out_chan[i]) + int'(out_word[i]) + int'(data_out[i] != 16'd0), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) apply(i, tbl[i]);

        // Reset while stage 1 of ch0 is computing
        pulse_reset();
        apply(100, '{0, 0, 1, 77, 0, 0, 0, 0, 0});
        apply(101, '{0, 0, 0, 10, 0, 0, 0, 0, 0});
        apply(102, '{0, 0, 0, 10, 1, 1, 0, 0, 0});
        apply(103, '{0, 0, 0, 10, 0, 0, 0, 0, 0});
        in_valid[0] = 1'b1;
        in_chan[0]  = 2'd0;
        data_in[0]  = 16'd10;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("midcalc stage0 word", int'(out_valid[0]) * 10 + int'(out_word[0]), 13);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midcalc quiet%0d valid*10+ready", i),
                int'(out_valid[0]) * 10 + int'(in_ready[0]), 1);
            @(negedge clk);
        end
        apply(104, '{0, 0, 1, 100, 0, 0, 0, 0, 0});
        apply(105, '{0, 0, 0, 100, 0, 0, 0, 0, 0});
        apply(106, '{0, 0, 0, 100, 1, 1, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
